// File: rtl/bus_load_master_if.sv
// bus_load_master_if: core load request/response plus the responder bus of bus_load_master.
interface bus_load_master_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic [1:0]  size_i;
  logic        signed_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        err_o;
  logic [31:0] bus_addr_o;
  logic        bus_cs_o;
  logic [1:0]  bus_hb_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  modport master (
    input  req_i, addr_i, size_i, signed_i, bus_rdata_i, bus_ack_i,
    output ready_o, valid_o, data_o, err_o, bus_addr_o, bus_cs_o, bus_hb_o
  );
  modport slave (
    output req_i, addr_i, size_i, signed_i, bus_rdata_i, bus_ack_i,
    input  ready_o, valid_o, data_o, err_o, bus_addr_o, bus_cs_o, bus_hb_o
  );
endinterface

// File: rtl/bus_load_master.sv
// bus_load_master: single-outstanding load unit with size extension; LOAD_TIMEOUT_EN adds an ACCESS timeout.
module bus_load_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk_i,
  input logic rst_i,
  bus_load_master_if.master b
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      r_state;
  logic        r_ready;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_data;
  logic        r_cs;
  logic [31:0] r_addr;
  logic [1:0]  r_hb;
  logic        r_signed;
  logic        w_mis;
  logic [31:0] w_ext;
`ifdef LOAD_TIMEOUT_EN
  logic [31:0] r_tcnt;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif
  assign w_mis = (b.size_i == 2'b10) ? b.addr_i[0] : (b.size_i != 2'b01) & (|b.addr_i[1:0]);
  assign w_ext = (r_hb == 2'b01) ? {{24{r_signed & b.bus_rdata_i[7]}}, b.bus_rdata_i[7:0]} :
                 (r_hb == 2'b10) ? {{16{r_signed & b.bus_rdata_i[15]}}, b.bus_rdata_i[15:0]} :
                 b.bus_rdata_i;
  assign b.ready_o    = r_ready;
  assign b.valid_o    = r_valid;
  assign b.err_o      = r_err;
  assign b.data_o     = r_data;
  assign b.bus_cs_o   = r_cs;
  assign b.bus_addr_o = r_addr;
  assign b.bus_hb_o   = r_hb;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_data   <= '0;
      r_cs     <= 1'b0;
      r_addr   <= '0;
      r_hb     <= '0;
      r_signed <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      r_tcnt   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (b.req_i) begin
          r_ready <= 1'b0;
          if (w_mis) begin
            r_state <= RESP;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            r_data  <= '0;
          end else begin
            r_state  <= ACCESS;
            r_cs     <= 1'b1;
            r_addr   <= b.addr_i;
            r_hb     <= b.size_i;
            r_signed <= b.signed_i;
`ifdef LOAD_TIMEOUT_EN
            r_tcnt   <= '0;
`endif
          end
        end
        ACCESS: begin
          if (b.bus_ack_i) begin
            r_state <= RESP;
            r_cs    <= 1'b0;
            r_valid <= 1'b1;
            r_err   <= 1'b0;
            r_data  <= w_ext;
          end
`ifdef LOAD_TIMEOUT_EN
          else begin
            r_tcnt <= r_tcnt + 32'd1;
            // an ack arriving in the expiry cycle wins via the branch above
            if (r_tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
              r_state <= RESP;
              r_cs    <= 1'b0;
              r_valid <= 1'b1;
              r_err   <= 1'b1;
              r_data  <= '0;
            end
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_load_master.sv
// tb_bus_load_master: planned per-cycle stimulus and expectations, checked every cycle.
module tb_bus_load_master;
  localparam int TO = 4;
  localparam int MAXC = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bus_load_master_if b();
  bus_load_master #(.TIMEOUT_CYCLES(TO)) dut (.clk_i(clk), .rst_i(rst), .b(b));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bit          d_rst [MAXC];
  bit          d_req [MAXC];
  bit          d_sgn [MAXC];
  bit          d_ack [MAXC];
  logic [31:0] d_addr [MAXC];
  logic [31:0] d_rdata [MAXC];
  logic [1:0]  d_size [MAXC];
  bit          e_rst [MAXC];
  bit          e_v [MAXC];
  bit          e_cs [MAXC];
  bit          e_e [MAXC];
  bit          e_rdy [MAXC];
  logic [31:0] e_d [MAXC];
  logic [31:0] e_a [MAXC];
  logic [1:0]  e_hb [MAXC];
  int t = 3;
  int last_c = MAXC - 1;
  int errs = 0;
  int checks = 0;
  function automatic logic [31:0] ext(logic [1:0] s, bit sg, logic [31:0] r);
    if (s == 2'b01) return sg ? 32'($signed(r[7:0])) : 32'(r[7:0]);
    if (s == 2'b10) return sg ? 32'($signed(r[15:0])) : 32'(r[15:0]);
    return r;
  endfunction
  function automatic bit mis(logic [31:0] a, logic [1:0] s);
    int al;
    al = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
    return (int'(a[1:0]) % al) != 0;
  endfunction
  task automatic junk(input int c);
    d_req[c]  = 1'($urandom);
    d_addr[c] = $urandom;
    d_size[c] = 2'($urandom);
    d_sgn[c]  = 1'($urandom);
  endtask
  task automatic plan(input logic [31:0] a, input logic [1:0] s, input bit sg, input int d,
                      input logic [31:0] rd, input bit lit, input logic [31:0] ld);
    int n, len, v;
    bit to_hit;
    d_req[t] = 1'b1; d_addr[t] = a; d_size[t] = s; d_sgn[t] = sg;
    n = t + 1;
    if (mis(a, s)) begin
      v = n;
      e_v[v] = 1'b1; e_e[v] = 1'b1; e_d[v] = '0;
    end else begin
      to_hit = 1'b0;
`ifdef LOAD_TIMEOUT_EN
      to_hit = d >= TO;
`endif
      len = to_hit ? TO : d + 1;
      for (int k = 0; k < len; k++) begin
        e_cs[n+k] = 1'b1; e_a[n+k] = a; e_hb[n+k] = s; e_rdy[n+k] = 1'b0;
      end
      if (!to_hit) begin
        d_ack[n+d] = 1'b1; d_rdata[n+d] = rd;
      end
      v = n + len;
      e_v[v] = 1'b1; e_e[v] = to_hit;
      e_d[v] = to_hit ? 32'h0 : lit ? ld : ext(s, sg, rd);
    end
    e_rdy[v] = 1'b0;
    d_ack[v] = 1'($urandom);
    for (int c = n; c <= v; c++) junk(c);
    t = v + 1;
  endtask
  task automatic plan_rst(input logic [31:0] a, input int k);
    int n;
    d_req[t] = 1'b1; d_addr[t] = a; d_size[t] = 2'b00; d_sgn[t] = 1'b0;
    n = t + 1;
    for (int j = 0; j < k; j++) begin
      e_cs[n+j] = 1'b1; e_a[n+j] = a; e_hb[n+j] = 2'b00; e_rdy[n+j] = 1'b0;
      junk(n + j);
    end
    d_rst[n+k-1] = 1'b1;
    e_rst[n+k] = 1'b1;
    t = n + k;
  endtask
  task automatic apply(input int c);
    rst           = d_rst[c];
    b.req_i       = d_req[c];
    b.addr_i      = d_addr[c];
    b.size_i      = d_size[c];
    b.signed_i    = d_sgn[c];
    b.bus_ack_i   = d_ack[c];
    b.bus_rdata_i = d_rdata[c];
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h, want %h", n, cyc, got, want);
    end
  endtask
  initial begin
    logic [31:0] hd, he;
    hd = '0; he = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < last_c) begin
        if (e_rst[cyc]) begin
          hd = '0; he = '0;
          chk("reset bus_addr", b.bus_addr_o, 32'h0);
          chk("reset bus_hb", 32'(b.bus_hb_o), 32'h0);
        end
        if (e_v[cyc]) begin
          hd = e_d[cyc]; he = 32'(e_e[cyc]);
        end
        chk("ready", 32'(b.ready_o), 32'(e_rdy[cyc]));
        chk("valid", 32'(b.valid_o), 32'(e_v[cyc]));
        chk("bus_cs", 32'(b.bus_cs_o), 32'(e_cs[cyc]));
        if (e_cs[cyc]) begin
          chk("bus_addr", b.bus_addr_o, e_a[cyc]);
          chk("bus_hb", 32'(b.bus_hb_o), 32'(e_hb[cyc]));
        end
        chk("data", b.data_o, hd);
        chk("err", 32'(b.err_o), he);
      end
    end
  end
  initial begin
    int gap, dl;
    logic [31:0] a;
    for (int c = 0; c < MAXC; c++) begin
      d_rst[c] = 1'b0; d_req[c] = 1'b0; d_sgn[c] = 1'b0; d_ack[c] = 1'b0;
      d_addr[c] = '0; d_size[c] = '0; d_rdata[c] = $urandom;
      e_rst[c] = 1'b0; e_v[c] = 1'b0; e_cs[c] = 1'b0; e_e[c] = 1'b0; e_rdy[c] = 1'b1;
      e_d[c] = '0; e_a[c] = '0; e_hb[c] = '0;
    end
    for (int c = 0; c < 3; c++) begin
      d_rst[c] = 1'b1; e_rst[c+1] = 1'b1;
    end
    plan(32'h3, 2'b01, 1'b1, 0, 32'h0000_0080, 1'b1, 32'hFFFF_FF80);
    plan(32'h2, 2'b10, 1'b0, 0, 32'hABCD_8001, 1'b1, 32'h0000_8001);
    plan(32'h2, 2'b10, 1'b1, 1, 32'hABCD_8001, 1'b1, 32'hFFFF_8001);
    plan(32'h6, 2'b00, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    plan(32'h10, 2'b11, 1'b1, 3, 32'h1234_5678, 1'b1, 32'h1234_5678);
`ifdef LOAD_TIMEOUT_EN
    plan(32'h20, 2'b00, 1'b0, 100, 32'h0, 1'b0, 32'h0);
`endif
    plan_rst(32'h40, 2);
    plan(32'h1, 2'b01, 1'b0, 0, 32'hFFFF_FF5A, 1'b1, 32'h0000_005A);
    for (int i = 0; i < 150 && t < MAXC - 40; i++) begin
      gap = int'($urandom_range(0, 2));
      for (int c = t; c < t + gap; c++) d_ack[c] = 1'($urandom);
      t += gap;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      dl = int'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) plan_rst(a & 32'hFFFF_FFFC, int'($urandom_range(1, TO - 1)));
      else plan(a, 2'($urandom), 1'($urandom), dl, $urandom, 1'b0, 32'h0);
    end
    last_c = t + 3;
    apply(0);
    while (cyc < last_c) begin
      @(negedge clk);
      apply(cyc);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bus_load_master.md
BUS_LOAD_MASTER -- requirements
Module: bus_load_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: number of ACCESS cycles without bus_ack_i before abort; used only when LOAD_TIMEOUT_EN is defined.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 req_i  input  1  core load request, sampled only when ready_o=1.
REQ-005 addr_i  input  32  byte address of the load.
REQ-006 size_i  input  2  access size: 2'b01 byte, 2'b10 halfword, other values word.
REQ-007 signed_i  input  1  1 = sign-extend byte/half result; 0 = zero-extend.
REQ-008 ready_o  output  1  unit idle and able to accept req_i.
REQ-009 valid_o  output  1  one-cycle pulse: data_o/err_o valid.
REQ-010 data_o  output  32  extended load result.
REQ-011 err_o  output  1  load failed (misaligned or timeout); qualified by valid_o.
REQ-012 bus_addr_o  output  32  byte address to responder.
REQ-013 bus_cs_o  output  1  chip select to responder.
REQ-014 bus_hb_o  output  2  size code to responder, same encoding as size_i.
REQ-015 bus_rdata_i  input  32  responder data, right-justified per size (byte in [7:0], half in [15:0], upper bits zero).
REQ-016 bus_ack_i  input  1  responder data valid this cycle; combinational responders tie it to 1.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; ready_o=1 only in IDLE.
REQ-018 IDLE with req_i=1: latch addr_i, size_i, signed_i; aligned -> ACCESS; misaligned -> RESP with err flag set, no bus access.
REQ-019 Misaligned: half with addr_i[0]=1; word with addr_i[1:0]!=0; bytes never misaligned.
REQ-020 bus_cs_o=1 only in ACCESS; bus_addr_o/bus_hb_o hold the latched values from ACCESS entry until return to IDLE.
REQ-021 ACCESS with bus_ack_i=1: capture bus_rdata_i, apply extension, -> RESP.
REQ-022 Extension: byte -> bit 7 replicated into [31:8] if signed, else zeros; half -> bit 15 into [31:16] if signed, else zeros; word -> unchanged, signed_i ignored.
REQ-023 Bits of bus_rdata_i above the access size are ignored.
REQ-024 RESP: valid_o=1 for exactly one cycle, -> IDLE; data_o and err_o hold their values until the next RESP.
REQ-025 Latency with zero-wait ack: req accepted at edge N, bus_cs_o high in cycle N+1, valid_o high in cycle N+2; each ack-delay cycle adds one.
REQ-026 Misaligned request: valid_o=1, err_o=1, data_o=0 in cycle N+1.
REQ-027 req_i is ignored outside IDLE; a new request is accepted in the same cycle ready_o returns high.

Reset
REQ-028 rst_i=1 at a clock edge -> state IDLE, ready_o=1, valid_o=0, err_o=0, data_o=0, bus_cs_o=0, bus_addr_o=0, bus_hb_o=0, timeout counter 0.
REQ-029 Reset during ACCESS or RESP aborts the load; no valid_o pulse for it.

Configuration
REQ-030 Macro LOAD_TIMEOUT_EN defined: a counter cleared on ACCESS entry increments each ACCESS cycle without ack; on reaching TIMEOUT_CYCLES -> RESP with err_o=1, data_o=0; an ack in the same cycle as expiry has priority (normal completion).
REQ-031 LOAD_TIMEOUT_EN undefined: no counter; ACCESS waits for bus_ack_i indefinitely.

Verification
REQ-032 Byte, signed, addr 0x0000_0003, bus_rdata_i 0x0000_0080, ack=1 -> valid_o at N+2, data_o 0xFFFF_FF80, err_o 0, bus_hb_o 2'b01.
REQ-033 Half, unsigned, addr 0x0000_0002, bus_rdata_i 0xABCD_8001 -> data_o 0x0000_8001; same with signed_i=1 -> 0xFFFF_8001.
REQ-034 Word at 0x0000_0006 -> no bus_cs_o pulse, valid_o at N+1, err_o 1, data_o 0.
REQ-035 Word at 0x0000_0010, ack delayed 3 cycles, rdata 0x1234_5678 -> bus_cs_o high 4 cycles, valid_o at N+5, data_o 0x1234_5678.
REQ-036 LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack held 0 -> err_o 1 with valid_o after 4 ACCESS cycles; bus_cs_o then low.
REQ-037 rst_i pulsed during ACCESS -> next cycle ready_o 1, bus_cs_o 0, no valid_o; a following byte load at 0x0000_0001 completes normally.
